// File: rtl/fetch_ir_queue_pkg.sv
`default_nettype none
// ============================================================================
// fetch_ir_queue_pkg : queue geometry and fetch FSM encoding
// Rev 1.0
// ============================================================================
package fetch_ir_queue_pkg;

  localparam int LINE_BYTES = 16;
  localparam int Q_BYTES    = 32;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fq_state_e;

endpackage
`default_nettype wire

// File: rtl/ir_window_rotator.sv
`default_nettype none
// ============================================================================
// ir_window_rotator : byte rotate of queue storage by head, MSB-first window
// Rev 1.0
// ============================================================================
module ir_window_rotator
  import fetch_ir_queue_pkg::*;
(
  input  logic [8*Q_BYTES-1:0]    i_data,
  input  logic [4:0]              i_head,
  output logic [8*LINE_BYTES-1:0] o_win
);

  logic [8*Q_BYTES-1:0] w_stage [0:5];

  assign w_stage[0] = i_data;

  for (genvar s = 0; s < 5; s++) begin : g_stage
    localparam int c_SH = 8 << s;
    assign w_stage[s+1] = i_head[s]
                        ? {w_stage[s][c_SH-1:0], w_stage[s][8*Q_BYTES-1:c_SH]}
                        : w_stage[s];
  end

  // Byte at head lands in the top byte of the window, then descending.
  for (genvar k = 0; k < LINE_BYTES; k++) begin : g_byte
    assign o_win[8*(LINE_BYTES-1-k) +: 8] = w_stage[5][8*k +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/fetch_ir_queue.sv
`default_nettype none
// ============================================================================
// fetch_ir_queue : 32-byte instruction queue feeding decode a 16-byte window
// Rev 1.0
// ============================================================================
module fetch_ir_queue
  import fetch_ir_queue_pkg::*;
#(
  parameter logic [31:0] RESET_EIP = 32'hFFFF_FFF0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         FE_REDIRECT,
  input  logic [31:0]  FE_REDIRECT_EIP,
  output logic         IC_REQ,
  output logic [31:0]  IC_ADDR,
  input  logic         IC_ACK,
  input  logic [127:0] IC_LINE,
  input  logic         IC_PF,
  output logic         D1_V,
  output logic [127:0] D1_IR,
  output logic [31:0]  D1_EIP,
  output logic         D1_PF_EXIST,
  input  logic         D1_STALL,
  input  logic [3:0]   D1_LEN
);

  localparam logic [31:0] c_LINE_MASK = ~32'(LINE_BYTES - 1);
  localparam logic [5:0]  c_LINE_CNT  = 6'(LINE_BYTES);

  fq_state_e    r_state, w_state_nxt;
  logic [4:0]   r_head;
  logic         r_tail;
  logic [5:0]   r_count, w_count_nxt, w_fill;
  logic [3:0]   r_skip;
  logic [31:0]  r_fetch_addr, w_fetch_nxt, r_ic_addr, r_eip;
  logic         r_pf_flag;
  logic [127:0] r_slot [0:1];
  logic         w_consume, w_ack_take, w_line_wr;

  assign D1_V        = (r_count >= c_LINE_CNT) | r_pf_flag;
  assign D1_PF_EXIST = r_pf_flag & (r_count < c_LINE_CNT);
  assign D1_EIP      = r_eip;
  assign IC_REQ      = (r_state != RUN);
  assign IC_ADDR     = r_ic_addr;

  assign w_consume  = D1_V & ~D1_STALL & (D1_LEN != 4'd0);
  assign w_ack_take = IC_ACK & (r_state == WAIT) & ~FE_REDIRECT;
  assign w_line_wr  = w_ack_take & ~IC_PF;
  assign w_fill     = c_LINE_CNT - {2'b00, r_skip};

  always_comb begin
    w_count_nxt = r_count + (w_line_wr ? w_fill : 6'd0)
                - (w_consume ? {2'b00, D1_LEN} : 6'd0);
    w_fetch_nxt = r_fetch_addr;
    if (FE_REDIRECT)
      w_fetch_nxt = FE_REDIRECT_EIP & c_LINE_MASK;
    else if (w_line_wr)
      w_fetch_nxt = r_fetch_addr + 32'(LINE_BYTES);
  end

  always_comb begin
    w_state_nxt = r_state;
    if (FE_REDIRECT) begin
      case (r_state)
        RUN:     w_state_nxt = WAIT;
        WAIT:    w_state_nxt = IC_ACK ? WAIT : DROP;
        DROP:    w_state_nxt = DROP;
        default: w_state_nxt = RUN;
      endcase
    end else begin
      case (r_state)
        RUN:     if (!r_pf_flag && w_count_nxt <= c_LINE_CNT) w_state_nxt = WAIT;
        WAIT:    if (IC_ACK) w_state_nxt = (!IC_PF && w_count_nxt <= c_LINE_CNT) ? WAIT : RUN;
        DROP:    if (IC_ACK) w_state_nxt = WAIT;
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_count      <= 6'd0;
      r_tail       <= 1'b0;
      r_pf_flag    <= 1'b0;
      r_head       <= {1'b0, RESET_EIP[3:0]};
      r_skip       <= RESET_EIP[3:0];
      r_eip        <= RESET_EIP;
      r_fetch_addr <= RESET_EIP & c_LINE_MASK;
      r_ic_addr    <= RESET_EIP & c_LINE_MASK;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_addr <= w_fetch_nxt;
      // DROP keeps presenting the stale address until its ack retires.
      if (w_state_nxt != DROP)
        r_ic_addr <= w_fetch_nxt;
      if (FE_REDIRECT) begin
        r_count   <= 6'd0;
        r_tail    <= 1'b0;
        r_head    <= {1'b0, FE_REDIRECT_EIP[3:0]};
        r_skip    <= FE_REDIRECT_EIP[3:0];
        r_eip     <= FE_REDIRECT_EIP;
        r_pf_flag <= 1'b0;
      end else begin
        r_count <= w_count_nxt;
        if (w_consume) begin
          r_head <= r_head + {1'b0, D1_LEN};
          r_eip  <= r_eip + {28'd0, D1_LEN};
        end
        if (w_line_wr) begin
          r_tail <= ~r_tail;
          r_skip <= 4'd0;
        end
        if (w_ack_take & IC_PF)
          r_pf_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_line_wr)
      r_slot[r_tail] <= IC_LINE;
  end

  ir_window_rotator u_rotator (
    .i_data ({r_slot[1], r_slot[0]}),
    .i_head (r_head),
    .o_win  (D1_IR)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_ir_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_ir_queue : self-checking bench for fetch_ir_queue (RESET_EIP=0x100)
// Rev 1.0
// ============================================================================
module tb_fetch_ir_queue;

  logic         clk = 1'b0;
  logic         reset;
  logic         FE_REDIRECT;
  logic [31:0]  FE_REDIRECT_EIP;
  logic         IC_REQ;
  logic [31:0]  IC_ADDR;
  logic         IC_ACK;
  logic [127:0] IC_LINE;
  logic         IC_PF;
  logic         D1_V;
  logic [127:0] D1_IR;
  logic [31:0]  D1_EIP;
  logic         D1_PF_EXIST;
  logic         D1_STALL;
  logic [3:0]   D1_LEN;

  int checks   = 0;
  int failures = 0;
  bit auto_ack = 1'b0;

  always #5 clk = ~clk;

  fetch_ir_queue #(.RESET_EIP(32'h0000_0100)) dut (
    .clk             (clk),
    .reset           (reset),
    .FE_REDIRECT     (FE_REDIRECT),
    .FE_REDIRECT_EIP (FE_REDIRECT_EIP),
    .IC_REQ          (IC_REQ),
    .IC_ADDR         (IC_ADDR),
    .IC_ACK          (IC_ACK),
    .IC_LINE         (IC_LINE),
    .IC_PF           (IC_PF),
    .D1_V            (D1_V),
    .D1_IR           (D1_IR),
    .D1_EIP          (D1_EIP),
    .D1_PF_EXIST     (D1_PF_EXIST),
    .D1_STALL        (D1_STALL),
    .D1_LEN          (D1_LEN)
  );

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    return a[7:0] ^ (a[15:8] * 8'd37);
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = byte_at(a + 32'(k));
    return l;
  endfunction

  function automatic logic [127:0] win_of(input logic [31:0] a);
    logic [127:0] w;
    for (int k = 0; k < 16; k++) w[127-8*k -: 8] = byte_at(a + 32'(k));
    return w;
  endfunction

  // The cache model answers every request in the cycle it is seen when enabled.
  task automatic tick();
    if (auto_ack) begin
      IC_ACK  = IC_REQ;
      IC_LINE = line_of(IC_ADDR);
      IC_PF   = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ack_line(input logic [31:0] a, input logic pf);
    IC_ACK = 1'b1; IC_LINE = line_of(a); IC_PF = pf;
    tick();
    IC_ACK = 1'b0; IC_PF = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] t);
    FE_REDIRECT = 1'b1; FE_REDIRECT_EIP = t;
    tick();
    FE_REDIRECT = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; FE_REDIRECT = 1'b0; FE_REDIRECT_EIP = '0;
    IC_ACK = 1'b0; IC_LINE = '0; IC_PF = 1'b0; D1_STALL = 1'b1; D1_LEN = 4'd3;
    tick(); tick();
    checks++; if (IC_REQ !== 1'b0) begin failures++; $display("FAIL reset_ic_req got=%0b exp=0", IC_REQ); end
    checks++; if (D1_V !== 1'b0) begin failures++; $display("FAIL reset_d1_v got=%0b exp=0", D1_V); end
    checks++; if (D1_PF_EXIST !== 1'b0) begin failures++; $display("FAIL reset_pf_exist got=%0b exp=0", D1_PF_EXIST); end
    checks++; if (D1_EIP !== 32'h100) begin failures++; $display("FAIL reset_eip got=%h exp=%h", D1_EIP, 32'h100); end
    reset = 1'b0;
    tick();
    checks++; if (IC_REQ !== 1'b1) begin failures++; $display("FAIL first_req got=%0b exp=1", IC_REQ); end
    checks++; if (IC_ADDR !== 32'h100) begin failures++; $display("FAIL first_addr got=%h exp=%h", IC_ADDR, 32'h100); end
    checks++; if (D1_V !== 1'b0) begin failures++; $display("FAIL first_d1_v got=%0b exp=0", D1_V); end
  endtask

  task automatic test_fill();
    ack_line(32'h100, 1'b0);
    checks++; if (D1_V !== 1'b1) begin failures++; $display("FAIL fill1_v got=%0b exp=1", D1_V); end
    checks++; if (D1_EIP !== 32'h100) begin failures++; $display("FAIL fill1_eip got=%h exp=%h", D1_EIP, 32'h100); end
    checks++; if (D1_IR !== win_of(32'h100)) begin failures++; $display("FAIL fill1_ir got=%h exp=%h", D1_IR, win_of(32'h100)); end
    checks++; if (IC_ADDR !== 32'h110 || IC_REQ !== 1'b1) begin failures++; $display("FAIL fill1_req got=%0b/%h exp=1/%h", IC_REQ, IC_ADDR, 32'h110); end
    ack_line(32'h110, 1'b0);
    checks++; if (IC_REQ !== 1'b0) begin failures++; $display("FAIL fill2_req_drop got=%0b exp=0", IC_REQ); end
    checks++; if (D1_IR !== win_of(32'h100)) begin failures++; $display("FAIL fill2_ir got=%h exp=%h", D1_IR, win_of(32'h100)); end
  endtask

  // Scoreboard: acked line bytes are pushed, consumed bytes popped; the
  // window must equal the first 16 queued bytes whenever 16 are available.
  task automatic test_consume();
    logic [7:0]   q[$];
    logic [31:0]  m_eip;
    logic [31:0]  m_fetch;
    logic [127:0] exp_ir;
    logic         mv;
    int           n;
    for (int k = 0; k < 32; k++) q.push_back(byte_at(32'h100 + 32'(k)));
    m_eip = 32'h100; m_fetch = 32'h120;
    auto_ack = 1'b1; D1_LEN = 4'd3;
    for (int c = 0; c < 48; c++) begin
      mv = (q.size() >= 16);
      checks++; if (D1_V !== mv) begin failures++; $display("FAIL consume_v cyc=%0d got=%0b exp=%0b", c, D1_V, mv); end
      if (mv) begin
        for (int k = 0; k < 16; k++) exp_ir[127-8*k -: 8] = q[k];
        checks++; if (D1_EIP !== m_eip) begin failures++; $display("FAIL consume_eip cyc=%0d got=%h exp=%h", c, D1_EIP, m_eip); end
        checks++; if (D1_IR !== exp_ir) begin failures++; $display("FAIL consume_ir cyc=%0d got=%h exp=%h", c, D1_IR, exp_ir); end
      end
      D1_STALL = (c % 7 == 6);
      if (IC_REQ) begin
        checks++; if (IC_ADDR !== m_fetch) begin failures++; $display("FAIL consume_addr cyc=%0d got=%h exp=%h", c, IC_ADDR, m_fetch); end
        for (int k = 0; k < 16; k++) q.push_back(byte_at(m_fetch + 32'(k)));
        m_fetch = m_fetch + 32'h10;
      end
      if (mv && !D1_STALL) begin
        for (int k = 0; k < 3; k++) void'(q.pop_front());
        m_eip = m_eip + 32'd3;
      end
      tick();
    end
    D1_STALL = 1'b1;
    n = 0;
    while (IC_REQ && n < 20) begin tick(); n++; end
    auto_ack = 1'b0; IC_ACK = 1'b0; IC_PF = 1'b0;
    checks++; if (IC_REQ !== 1'b0) begin failures++; $display("FAIL drain_timeout got=%0b exp=0", IC_REQ); end
  endtask

  task automatic test_redirect_unaligned();
    redirect(32'h2007);
    checks++; if (IC_REQ !== 1'b1 || IC_ADDR !== 32'h2000) begin failures++; $display("FAIL ru_req got=%0b/%h exp=1/%h", IC_REQ, IC_ADDR, 32'h2000); end
    checks++; if (D1_V !== 1'b0) begin failures++; $display("FAIL ru_v0 got=%0b exp=0", D1_V); end
    ack_line(32'h2000, 1'b0);
    checks++; if (D1_V !== 1'b0) begin failures++; $display("FAIL ru_v_after_first got=%0b exp=0", D1_V); end
    checks++; if (IC_ADDR !== 32'h2010) begin failures++; $display("FAIL ru_addr2 got=%h exp=%h", IC_ADDR, 32'h2010); end
    ack_line(32'h2010, 1'b0);
    checks++; if (D1_V !== 1'b1) begin failures++; $display("FAIL ru_v_after_second got=%0b exp=1", D1_V); end
    checks++; if (D1_EIP !== 32'h2007) begin failures++; $display("FAIL ru_eip got=%h exp=%h", D1_EIP, 32'h2007); end
    checks++; if (D1_IR !== win_of(32'h2007)) begin failures++; $display("FAIL ru_ir got=%h exp=%h", D1_IR, win_of(32'h2007)); end
    checks++; if (IC_REQ !== 1'b0) begin failures++; $display("FAIL ru_req_drop got=%0b exp=0", IC_REQ); end
  endtask

  task automatic test_drop();
    redirect(32'h140);
    checks++; if (IC_ADDR !== 32'h140) begin failures++; $display("FAIL drop_setup got=%h exp=%h", IC_ADDR, 32'h140); end
    redirect(32'h3000);
    checks++; if (IC_REQ !== 1'b1 || IC_ADDR !== 32'h140) begin failures++; $display("FAIL drop_hold1 got=%0b/%h exp=1/%h", IC_REQ, IC_ADDR, 32'h140); end
    tick();
    checks++; if (IC_ADDR !== 32'h140) begin failures++; $display("FAIL drop_hold2 got=%h exp=%h", IC_ADDR, 32'h140); end
    ack_line(32'h140, 1'b1);
    checks++; if (IC_REQ !== 1'b1 || IC_ADDR !== 32'h3000) begin failures++; $display("FAIL drop_newaddr got=%0b/%h exp=1/%h", IC_REQ, IC_ADDR, 32'h3000); end
    checks++; if (D1_V !== 1'b0 || D1_PF_EXIST !== 1'b0) begin failures++; $display("FAIL drop_discard got=%0b/%0b exp=0/0", D1_V, D1_PF_EXIST); end
    ack_line(32'h3000, 1'b0);
    checks++; if (D1_V !== 1'b1) begin failures++; $display("FAIL drop_v got=%0b exp=1", D1_V); end
    checks++; if (D1_IR !== win_of(32'h3000)) begin failures++; $display("FAIL drop_ir got=%h exp=%h", D1_IR, win_of(32'h3000)); end
    checks++; if (IC_ADDR !== 32'h3010) begin failures++; $display("FAIL drop_next got=%h exp=%h", IC_ADDR, 32'h3010); end
  endtask

  task automatic test_redirect_ack();
    FE_REDIRECT = 1'b1; FE_REDIRECT_EIP = 32'h4000;
    ack_line(32'h3010, 1'b0);
    FE_REDIRECT = 1'b0;
    checks++; if (IC_REQ !== 1'b1 || IC_ADDR !== 32'h4000) begin failures++; $display("FAIL rack_addr got=%0b/%h exp=1/%h", IC_REQ, IC_ADDR, 32'h4000); end
    checks++; if (D1_V !== 1'b0) begin failures++; $display("FAIL rack_v got=%0b exp=0", D1_V); end
    ack_line(32'h4000, 1'b0);
    checks++; if (D1_V !== 1'b1 || D1_EIP !== 32'h4000) begin failures++; $display("FAIL rack_v2 got=%0b/%h exp=1/%h", D1_V, D1_EIP, 32'h4000); end
    checks++; if (D1_IR !== win_of(32'h4000)) begin failures++; $display("FAIL rack_ir got=%h exp=%h", D1_IR, win_of(32'h4000)); end
    ack_line(32'h4010, 1'b0);
    checks++; if (IC_REQ !== 1'b0) begin failures++; $display("FAIL rack_full got=%0b exp=0", IC_REQ); end
  endtask

  task automatic test_pf();
    logic [127:0] w;
    redirect(32'h116);
    checks++; if (IC_ADDR !== 32'h110) begin failures++; $display("FAIL pf_addr1 got=%h exp=%h", IC_ADDR, 32'h110); end
    ack_line(32'h110, 1'b0);
    checks++; if (D1_V !== 1'b0 || IC_ADDR !== 32'h120) begin failures++; $display("FAIL pf_count10 got=%0b/%h exp=0/%h", D1_V, IC_ADDR, 32'h120); end
    ack_line(32'h120, 1'b1);
    w = win_of(32'h116);
    checks++; if (IC_REQ !== 1'b0) begin failures++; $display("FAIL pf_req got=%0b exp=0", IC_REQ); end
    checks++; if (D1_V !== 1'b1 || D1_PF_EXIST !== 1'b1) begin failures++; $display("FAIL pf_flags got=%0b/%0b exp=1/1", D1_V, D1_PF_EXIST); end
    checks++; if (D1_IR[127:48] !== w[127:48]) begin failures++; $display("FAIL pf_ir got=%h exp=%h", D1_IR[127:48], w[127:48]); end
    tick();
    checks++; if (IC_REQ !== 1'b0) begin failures++; $display("FAIL pf_req_hold got=%0b exp=0", IC_REQ); end
    D1_STALL = 1'b0; D1_LEN = 4'd0;
    tick();
    checks++; if (D1_EIP !== 32'h116) begin failures++; $display("FAIL len0_eip got=%h exp=%h", D1_EIP, 32'h116); end
    D1_LEN = 4'd10;
    tick();
    D1_STALL = 1'b1;
    checks++; if (D1_EIP !== 32'h120) begin failures++; $display("FAIL pf_consume_eip got=%h exp=%h", D1_EIP, 32'h120); end
    checks++; if (D1_V !== 1'b1 || D1_PF_EXIST !== 1'b1 || IC_REQ !== 1'b0) begin failures++; $display("FAIL pf_empty got=%0b/%0b/%0b exp=1/1/0", D1_V, D1_PF_EXIST, IC_REQ); end
    redirect(32'h500);
    checks++; if (D1_PF_EXIST !== 1'b0 || D1_V !== 1'b0) begin failures++; $display("FAIL pf_clear got=%0b/%0b exp=0/0", D1_PF_EXIST, D1_V); end
    checks++; if (IC_REQ !== 1'b1 || IC_ADDR !== 32'h500) begin failures++; $display("FAIL pf_refetch got=%0b/%h exp=1/%h", IC_REQ, IC_ADDR, 32'h500); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_consume();
    test_redirect_unaligned();
    test_drop();
    test_redirect_ack();
    test_pf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
